// File: rtl/sum_acc_pkg.sv
// sum_accumulator shared types and helpers.
// FSM state encoding and beat-counter sizing.
package sum_acc_pkg;

   typedef enum logic {
      ACCUM,
      HOLD
   } acc_state_t;

   // Beat counter needs at least one bit, even for COUNT=1.
   function automatic int cnt_width(input int count);
      int w;
      w = $clog2(count);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT beats of WIDTH-bit adder results
// into an ACC_WIDTH-bit block total with a sticky carry-out flag.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int COUNT     = 4,
   parameter int ACC_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 out_ovf
);

   localparam int CW = cnt_width(COUNT);
   localparam int XW = ACC_WIDTH + 1 - WIDTH;
   localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

   acc_state_t           state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [CW-1:0]        cnt_q;
   logic                 ovf_q;
   logic [ACC_WIDTH-1:0] out_data_q;
   logic                 out_ovf_q;

   logic                 accept;
   logic                 last_beat;
   logic [ACC_WIDTH:0]   sum;

   // Handshake, carry-extended add and next-state selection.
   always_comb begin
      state_d   = state_q;
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == HOLD);
      accept    = in_valid && in_ready;
      last_beat = accept && (cnt_q == LAST);
      sum       = {1'b0, acc_q} + {{XW{1'b0}}, in_data};
      unique case (state_q)
         ACCUM: if (last_beat) state_d = HOLD;
         HOLD:  if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
      if (clear) state_d = ACCUM;
   end

   // State register and accumulation datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACCUM;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else if (accept) begin
            if (last_beat) begin
               out_data_q <= sum[ACC_WIDTH-1:0];
               out_ovf_q  <= ovf_q | sum[ACC_WIDTH];
               acc_q      <= '0;
               cnt_q      <= '0;
               ovf_q      <= 1'b0;
            end else begin
               acc_q <= sum[ACC_WIDTH-1:0];
               cnt_q <= cnt_q + CW'(1);
               ovf_q <= ovf_q | sum[ACC_WIDTH];
            end
         end
      end
   end

   assign out_data = out_data_q;
   assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator (ACC_WIDTH 10 and 9
// instances in lockstep on shared stimulus).
module tb_sum_accumulator;

   typedef struct {
      int unsigned data;
      bit          ovf;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       out_ready;
   logic       rdy_fixed = 1'b1;
   logic       rand_mode = 1'b0;
   logic       rnd_bit = 1'b0;

   logic       in_ready10, out_valid10, out_ovf10;
   logic [9:0] out_data10;
   logic       in_ready9, out_valid9, out_ovf9;
   logic [8:0] out_data9;

   res_t q10[$];
   res_t q9[$];
   int   n_chk = 0;
   int   n_fail = 0;

   assign out_ready = rand_mode ? rnd_bit : rdy_fixed;

   always #5 clk = ~clk;

   sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready10), .in_data(in_data),
      .out_valid(out_valid10), .out_ready(out_ready),
      .out_data(out_data10), .out_ovf(out_ovf10)
   );

   sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready9), .in_data(in_data),
      .out_valid(out_valid9), .out_ready(out_ready),
      .out_data(out_data9), .out_ovf(out_ovf9)
   );

   task automatic chk(input string nm, input int unsigned act,
                      input int unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int unsigned d10, input bit o10,
                       input int unsigned d9, input bit o9);
      res_t r;
      r.data = d10; r.ovf = o10; q10.push_back(r);
      r.data = d9;  r.ovf = o9;  q9.push_back(r);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send_beat(input logic [7:0] d);
      bit ok;
      int n;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      do begin
         ok = in_ready10;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 1000);
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic send_block(input int unsigned a, input int unsigned b,
                             input int unsigned c, input int unsigned d);
      send_beat(8'(a)); send_beat(8'(b));
      send_beat(8'(c)); send_beat(8'(d));
      in_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   // Monitor: pop and compare on each output handshake, and check
   // that a stalled result stays stable.
   bit          stall_q = 1'b0;
   logic [9:0]  hold_d;
   logic        hold_o;
   always @(negedge clk) begin
      res_t r;
      if (stall_q && out_valid10) begin
         chk("hold_data", out_data10, hold_d);
         chk("hold_ovf", out_ovf10, hold_o);
      end
      stall_q = out_valid10 && !out_ready;
      hold_d  = out_data10;
      hold_o  = out_ovf10;
      if (out_valid10 && out_ready) begin
         if (q10.size() == 0) chk("unexpected_result10", 1, 0);
         else begin
            r = q10.pop_front();
            chk("out_data10", out_data10, r.data);
            chk("out_ovf10", out_ovf10, r.ovf);
         end
      end
      if (out_valid9 && out_ready) begin
         if (q9.size() == 0) chk("unexpected_result9", 1, 0);
         else begin
            r = q9.pop_front();
            chk("out_data9", out_data9, r.data);
            chk("out_ovf9", out_ovf9, r.ovf);
         end
      end
   end

   initial begin
      int unsigned b[4];
      int unsigned tot;
      int n;

      #3;
      chk("rst_out_valid", out_valid10, 0);
      chk("rst_in_ready", in_ready10, 1);
      chk("rst_out_data", out_data10, 0);
      chk("rst_out_ovf", out_ovf10, 0);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back block, latency and one-cycle HOLD.
      push(100, 0, 100, 0);
      send_beat(10); send_beat(20); send_beat(30);
      chk("pre_last_out_valid", out_valid10, 0);
      send_beat(40);
      in_valid = 1'b0;
      chk("lat_out_valid", out_valid10, 1);
      chk("lat_in_ready", in_ready10, 0);
      chk("lat_out_data", out_data10, 100);
      @(posedge clk); #1;
      chk("post_out_valid", out_valid10, 0);
      chk("post_in_ready", in_ready10, 1);

      // Wrap and sticky overflow, then sticky cleared.
      push(1020, 0, 508, 1);
      send_block(255, 255, 255, 255);
      push(4, 0, 4, 0);
      send_block(1, 1, 1, 1);
      @(posedge clk); #1;

      // Backpressure: result held, in_valid ignored.
      rdy_fixed = 1'b0;
      push(10, 0, 10, 0);
      send_block(1, 2, 3, 4);
      in_valid = 1'b1;
      in_data  = 200;
      repeat (5) begin
         chk("bp_in_ready", in_ready10, 0);
         chk("bp_out_valid", out_valid10, 1);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      rdy_fixed = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", in_ready10, 1);
      chk("bp_release_out_valid", out_valid10, 0);

      // Clear discards partial block and the same-cycle beat.
      send_beat(5); send_beat(6);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 99;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      push(10, 0, 10, 0);
      send_block(1, 2, 3, 4);
      @(posedge clk); #1;

      // Async reset mid-block, then mid-HOLD.
      send_beat(50); send_beat(50); send_beat(50);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready10, 1);
      chk("rst_mid_out_valid", out_valid10, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      rdy_fixed = 1'b0;
      send_block(9, 9, 9, 9);
      chk("hold_before_rst", out_valid10, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_hold_out_valid", out_valid10, 0);
      chk("rst_hold_out_data", out_data10, 0);
      chk("rst_hold_out_ovf", out_ovf10, 0);
      #3 rst_n = 1'b1;
      rdy_fixed = 1'b1;
      @(posedge clk); #1;
      push(28, 0, 28, 0);
      send_block(7, 7, 7, 7);

      // Random bubbles and backpressure.
      rand_mode = 1'b1;
      for (int k = 0; k < 200; k++) begin
         tot = 0;
         for (int j = 0; j < 4; j++) begin
            b[j] = $urandom_range(0, 255);
            tot += b[j];
         end
         push(tot % 1024, 0, tot % 512, tot >= 512);
         for (int j = 0; j < 4; j++) begin
            in_valid = 1'b0;
            while ($urandom_range(0, 1) == 1) begin
               @(posedge clk); #1;
            end
            send_beat(8'(b[j]));
         end
         in_valid = 1'b0;
      end

      n = 0;
      while ((q10.size() != 0 || q9.size() != 0) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_q10", q10.size(), 0);
      chk("drain_q9", q9.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
